multicycle_control: RTL and testbench

Main control unit for the multicycle MIPS core. A Moore state machine reads `op` and `funct` from the datapath's instruction register and drives every datapath control strobe: PC write enables, memory read/write, IR load, register-file write, and the ALU operand selects and ALU operation. It also keeps a retired-instruction counter and flags illegal instructions for debug and test.

---
 rtl/multicycle_control_if.sv | 34 +++
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fields in, datapath control strobes and debug status out.
// master drives op/funct (datapath side); slave is the control unit.
interface multicycle_control_if #(parameter int INSTR_CNT_W = 32);
    logic [5:0] op;
    logic [5:0] funct;
    logic pcWriteCond;
    logic pcWrite;
    logic iOrD;
    logic memRead;
    logic memWrite;
    logic memToReg;
    logic irWrite;
    logic [1:0] pcSource;
    logic [2:0] aluControl;
    logic [1:0] aluSrcB;
    logic aluSrcA;
    logic regWrite;
    logic regDst;
    logic [3:0] state;
    logic illegalOp;
    logic [INSTR_CNT_W-1:0] instrCount;
    modport master (
        output op, funct,
        input pcWriteCond, pcWrite, iOrD, memRead, memWrite, memToReg, irWrite,
        input pcSource, aluControl, aluSrcB, aluSrcA, regWrite, regDst,
        input state, illegalOp, instrCount
    );
    modport slave (
        input op, funct,
        output pcWriteCond, pcWrite, iOrD, memRead, memWrite, memToReg, irWrite,
        output pcSource, aluControl, aluSrcB, aluSrcA, regWrite, regDst,
        output state, illegalOp, instrCount
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the multicycle MIPS datapath.
// Ports: clk, rst (async, active high), bus (slave: op/funct in; strobes, state, illegalOp, instrCount out).
module multicycle_control #(
    parameter int INSTR_CNT_W = 32
) (
    input logic clk,
    input logic rst,
    multicycle_control_if.slave bus
);
    typedef enum logic [3:0] {
        RESET  = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12
    } state_t;
    typedef struct packed {
        logic pc_write_cond;
        logic pc_write;
        logic i_or_d;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic ir_write;
        logic [1:0] pc_source;
        logic [2:0] alu_control;
        logic [1:0] alu_src_b;
        logic alu_src_a;
        logic reg_write;
        logic reg_dst;
    } ctrl_t;
    localparam logic [5:0] OP_R = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    function automatic logic [2:0] alu_op(logic [5:0] f);
        return f == F_SUB ? 3'b110 :
               f == F_AND ? 3'b000 :
               f == F_OR  ? 3'b001 :
               f == F_SLT ? 3'b111 : 3'b010;
    endfunction
    function automatic ctrl_t decode(state_t s, logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read = 1'b1;
                c.ir_write = 1'b1;
                c.pc_write = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_control = 3'b010;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_control = 3'b010;
            end
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_control = 3'b010;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d = 1'b1;
            end
            MEMWB: begin
                c.reg_write = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_control = alu_op(f);
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_control = 3'b110;
                c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01;
            end
            JUMP: begin
                c.pc_write = 1'b1;
                c.pc_source = 2'b10;
            end
            ADDIWB: c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction
    state_t state_q, state_d;
    ctrl_t ctrl_q, ctrl_d;
    logic [INSTR_CNT_W-1:0] cnt_q, cnt_d;
    logic funct_ok, op_ok, retire;
    // Outputs are registered from the next state, so they line up with state_q
    // and clear immediately with the async reset. funct is stable across
    // DECODE/EXEC, so the EXEC ALU op can be decoded one cycle early.
    always_comb begin
        funct_ok = bus.funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
        op_ok = bus.op inside {OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI} || (bus.op == OP_R && funct_ok);
        retire = state_q inside {MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB};
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: state_d = !op_ok ? FETCH :
                              bus.op == OP_R ? EXEC :
                              bus.op == OP_BEQ ? BRANCH :
                              bus.op == OP_J ? JUMP :
                              bus.op == OP_ADDI ? ADDIEX : MEMADR;
            MEMADR: state_d = bus.op == OP_LW ? MEMRD : MEMWR;
            MEMRD: state_d = MEMWB;
            EXEC: state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
        ctrl_d = decode(state_d, bus.funct);
        cnt_d = retire ? cnt_q + INSTR_CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET;
            ctrl_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q <= ctrl_d;
            cnt_q <= cnt_d;
        end
    end
    assign bus.pcWriteCond = ctrl_q.pc_write_cond;
    assign bus.pcWrite = ctrl_q.pc_write;
    assign bus.iOrD = ctrl_q.i_or_d;
    assign bus.memRead = ctrl_q.mem_read;
    assign bus.memWrite = ctrl_q.mem_write;
    assign bus.memToReg = ctrl_q.mem_to_reg;
    assign bus.irWrite = ctrl_q.ir_write;
    assign bus.pcSource = ctrl_q.pc_source;
    assign bus.aluControl = ctrl_q.alu_control;
    assign bus.aluSrcB = ctrl_q.alu_src_b;
    assign bus.aluSrcA = ctrl_q.alu_src_a;
    assign bus.regWrite = ctrl_q.reg_write;
    assign bus.regDst = ctrl_q.reg_dst;
    assign bus.state = state_q;
    // illegalOp depends on the freshly loaded IR, so it is decoded combinationally in DECODE.
    assign bus.illegalOp = state_q == DECODE && !op_ok;
    assign bus.instrCount = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; per-instruction cycle expectations queued by the driver, checked by a negedge monitor.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int retired = 0;
    logic running = 1'b0;
    typedef struct {
        logic [3:0] st;
        logic [16:0] ctl;
        logic ill;
        logic [3:0] cnt;
    } rec_t;
    rec_t exp_q[$];
    logic [16:0] dut_ctl;
    multicycle_control_if #(.INSTR_CNT_W(4)) bus();
    multicycle_control #(.INSTR_CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign dut_ctl = {bus.pcWriteCond, bus.pcWrite, bus.iOrD, bus.memRead, bus.memWrite, bus.memToReg,
                      bus.irWrite, bus.pcSource, bus.aluControl, bus.aluSrcB, bus.aluSrcA, bus.regWrite, bus.regDst};
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic legal(logic [5:0] o, logic [5:0] f);
        return o inside {6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000} ||
               (o == 6'b000000 && f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
    endfunction
    // Expected strobes per state, bit order:
    // pcWriteCond pcWrite iOrD memRead memWrite memToReg irWrite pcSource[2] aluControl[3] aluSrcB[2] aluSrcA regWrite regDst
    function automatic logic [16:0] exp_out(int s, logic [5:0] f);
        logic [2:0] ac;
        ac = f == 6'b100010 ? 3'b110 : f == 6'b100100 ? 3'b000 : f == 6'b100101 ? 3'b001 :
             f == 6'b101010 ? 3'b111 : 3'b010;
        case (s)
            1: return 17'b0_1_0_1_0_0_1_00_010_01_0_0_0;
            2: return 17'b0_0_0_0_0_0_0_00_010_11_0_0_0;
            3, 11: return 17'b0_0_0_0_0_0_0_00_010_10_1_0_0;
            4: return 17'b0_0_1_1_0_0_0_00_000_00_0_0_0;
            5: return 17'b0_0_0_0_0_1_0_00_000_00_0_1_0;
            6: return 17'b0_0_1_0_1_0_0_00_000_00_0_0_0;
            7: return {9'b0, ac, 5'b00_1_0_0};
            8: return 17'b0_0_0_0_0_0_0_00_000_00_0_1_1;
            9: return 17'b1_0_0_0_0_0_0_01_110_00_1_0_0;
            10: return 17'b0_1_0_0_0_0_0_10_000_00_0_0_0;
            12: return 17'b0_0_0_0_0_0_0_00_000_00_0_1_0;
            default: return 17'b0;
        endcase
    endfunction
    function automatic rec_t mk(int s, logic [5:0] f, logic ill);
        rec_t r;
        r.st = 4'(s);
        r.ctl = exp_out(s, f);
        r.ill = ill;
        r.cnt = 4'(retired);
        return r;
    endfunction
    // Called just after the edge entering FETCH; returns just after the edge entering the next FETCH.
    task automatic issue(input logic [5:0] o, input logic [5:0] f);
        int seq[$];
        logic ill;
        ill = !legal(o, f);
        seq = {1, 2};
        if (!ill)
            case (o)
                6'b100011: seq = {1, 2, 3, 4, 5};
                6'b101011: seq = {1, 2, 3, 6};
                6'b000000: seq = {1, 2, 7, 8};
                6'b001000: seq = {1, 2, 11, 12};
                6'b000100: seq = {1, 2, 9};
                default: seq = {1, 2, 10};
            endcase
        foreach (seq[k]) exp_q.push_back(mk(seq[k], f, ill && seq[k] == 2));
        @(posedge clk);
        #1 op_drive(o, f);
        repeat (seq.size() - 1) @(posedge clk);
        #1;
        if (!ill) retired = (retired + 1) % 16;
    endtask
    task automatic op_drive(input logic [5:0] o, input logic [5:0] f);
        bus.op = o;
        bus.funct = f;
    endtask
    task automatic issue_random();
        logic [5:0] o, f;
        f = 6'($urandom_range(0, 63));
        case ($urandom_range(0, 7))
            0: o = 6'b100011;
            1: o = 6'b101011;
            2: begin
                o = 6'b000000;
                case ($urandom_range(0, 4))
                    0: f = 6'b100000;
                    1: f = 6'b100010;
                    2: f = 6'b100100;
                    3: f = 6'b100101;
                    default: f = 6'b101010;
                endcase
            end
            3: o = 6'b001000;
            4: o = 6'b000100;
            5: o = 6'b000010;
            6: begin
                o = 6'($urandom_range(0, 63));
                while (legal(o, f) || o == 6'b000000) o = 6'($urandom_range(0, 63));
            end
            default: begin
                o = 6'b000000;
                while (legal(o, f)) f = 6'($urandom_range(0, 63));
            end
        endcase
        issue(o, f);
    endtask
    always @(negedge clk) begin
        if (running) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                rec_t r;
                r = exp_q.pop_front();
                check("state", 32'(bus.state), 32'(r.st));
                check("ctrl", 32'(dut_ctl), 32'(r.ctl));
                check("illegalOp", 32'(bus.illegalOp), 32'(r.ill));
                check("instrCount", 32'(bus.instrCount), 32'(r.cnt));
            end
            check("mem_rd_wr_excl", 32'(bus.memRead & bus.memWrite), 32'd0);
            check("pc_wr_excl", 32'(bus.pcWrite & bus.pcWriteCond), 32'd0);
        end
    end
    initial begin
        op_drive(6'b0, 6'b0);
        repeat (3) exp_q.push_back(mk(0, 6'b0, 1'b0));
        running = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        issue(6'b100011, 6'b000000);
        issue(6'b000000, 6'b100010);
        issue(6'b000000, 6'b101010);
        issue(6'b000100, 6'b010101);
        issue(6'b000010, 6'b111111);
        issue(6'b111111, 6'b000000);
        issue(6'b000000, 6'b000000);
        issue(6'b101011, 6'b000000);
        issue(6'b001000, 6'b100010);
        repeat (60) issue_random();
        // lw interrupted by an asynchronous reset while in MEMRD
        foreach (exp_q[k]) check("queue_empty_before_abort", 32'd1, 32'd0);
        exp_q.push_back(mk(1, 6'b0, 1'b0));
        exp_q.push_back(mk(2, 6'b0, 1'b0));
        exp_q.push_back(mk(3, 6'b0, 1'b0));
        exp_q.push_back(mk(4, 6'b0, 1'b0));
        @(posedge clk);
        #1 op_drive(6'b100011, 6'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_state", 32'(bus.state), 32'd0);
        check("abort_ctrl", 32'(dut_ctl), 32'd0);
        check("abort_illegalOp", 32'(bus.illegalOp), 32'd0);
        check("abort_instrCount", 32'(bus.instrCount), 32'd0);
        exp_q.delete();
        retired = 0;
        exp_q.push_back(mk(0, 6'b0, 1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (40) issue_random();
        running = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
